// File: rtl/lsu_mmio.sv
// Load/store unit with DMEM and memory-mapped UART TX FIFO, one-cycle load latency.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mmio #(
  parameter int          UART_FIFO_DEPTH = 4,
  parameter logic [19:0] UART_PAGE       = 20'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode_e,
  input  logic [2:0]  fun3_e,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [31:0] dm_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_mask,
  output logic        dm_we,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        misalign_err,
  output logic        map_err
);

  localparam int AW = $clog2(UART_FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
  typedef enum logic [1:0] {LD_ZERO, LD_DMEM, LD_STATUS} ldsrc_e;

  size_e       size;
  logic        uns;
  logic        is_ld, is_st, acc;
  logic [1:0]  lo_al;
  logic [11:0] uoff;
  logic        in_dmem, in_uart, is_tx, is_stat, unmapped, bad_map;
  logic        mis_trap;

  assign is_ld = (opcode_e == 7'b0000011);
  assign is_st = (opcode_e == 7'b0100011);
  assign acc   = is_ld || is_st;

  // Illegal size encodings fall through to word access.
  always_comb begin
    size = SZ_W;
    uns  = 1'b0;
    case (fun3_e)
      3'b000: size = SZ_B;
      3'b001: size = SZ_H;
      3'b100: begin size = SZ_B; uns = 1'b1; end
      3'b101: begin size = SZ_H; uns = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    case (size)
      SZ_B:    lo_al = addr[1:0];
      SZ_H:    lo_al = {addr[1], 1'b0};
      default: lo_al = 2'b00;
    endcase
  end

  assign uoff     = {addr[11:2], lo_al};
  assign in_dmem  = (addr[31:12] == 20'd0);
  assign in_uart  = (addr[31:12] == UART_PAGE);
  assign is_tx    = in_uart && (uoff == 12'h000);
  assign is_stat  = in_uart && (uoff == 12'h004);
  assign unmapped = !in_dmem && !is_tx && !is_stat;
  assign bad_map  = acc && (unmapped || (is_st && is_stat));

  // ---------------- store path ----------------
  always_comb begin
    dm_mask  = 4'b1111;
    dm_wdata = wd;
    case (size)
      SZ_B: begin
        dm_mask  = 4'b0001 << lo_al;
        dm_wdata = {4{wd[7:0]}};
      end
      SZ_H: begin
        dm_mask  = lo_al[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{wd[15:0]}};
      end
      default: ;
    endcase
  end

  assign dm_addr = {addr[31:2], 2'b00};
  assign dm_we   = is_st && in_dmem && !mis_trap;

  // ---------------- UART TX FIFO ----------------
  logic [7:0]    fifo_q [UART_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;

  assign full  = (cnt_q == CW'(UART_FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  // Stall looks at full only so a same-cycle pop cannot create a comb path from ready.
  assign stall = is_st && is_tx && full && !mis_trap;
  assign push  = is_st && is_tx && !full && !mis_trap;
  assign pop   = !empty && uart_tx_ready;

  assign uart_tx_valid = !empty;
  assign uart_tx_data  = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < UART_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) fifo_q[wr_ptr_q] <= wd[7:0];
    end
  end

  // ---------------- load pipeline ----------------
  logic        ld_pend_q;
  logic [1:0]  ld_lane_q;
  size_e       ld_size_q;
  logic        ld_uns_q;
  ldsrc_e      ld_src_q, ld_src_d;
  logic        map_err_q;

  always_comb begin
    ld_src_d = LD_ZERO;
    if (mis_trap)     ld_src_d = LD_ZERO;
    else if (in_dmem) ld_src_d = LD_DMEM;
    else if (is_stat) ld_src_d = LD_STATUS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_pend_q <= 1'b0;
      ld_lane_q <= 2'b00;
      ld_size_q <= SZ_W;
      ld_uns_q  <= 1'b0;
      ld_src_q  <= LD_ZERO;
      map_err_q <= 1'b0;
    end else begin
      ld_pend_q <= is_ld;
      ld_lane_q <= lo_al;
      ld_size_q <= size;
      ld_uns_q  <= uns;
      ld_src_q  <= ld_src_d;
      map_err_q <= bad_map;
    end
  end

  logic [7:0]  b_sel;
  logic [15:0] h_sel;
  logic [31:0] dm_fmt, status_word;

  always_comb begin
    case (ld_lane_q)
      2'd0:    b_sel = dm_rdata[7:0];
      2'd1:    b_sel = dm_rdata[15:8];
      2'd2:    b_sel = dm_rdata[23:16];
      default: b_sel = dm_rdata[31:24];
    endcase
    h_sel = ld_lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (ld_size_q)
      SZ_B:    dm_fmt = {{24{!ld_uns_q && b_sel[7]}}, b_sel};
      SZ_H:    dm_fmt = {{16{!ld_uns_q && h_sel[15]}}, h_sel};
      default: dm_fmt = dm_rdata;
    endcase
  end

  assign status_word = {16'b0, 8'(cnt_q), 6'b0, full, empty};

  always_comb begin
    load_data = 32'b0;
    if (ld_pend_q) begin
      case (ld_src_q)
        LD_DMEM:   load_data = dm_fmt;
        LD_STATUS: load_data = status_word;
        default:   load_data = 32'b0;
      endcase
    end
  end

  assign load_valid = ld_pend_q;
  assign map_err    = map_err_q;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned, misalign_q;
  assign misaligned = ((size == SZ_H) && addr[0]) || ((size == SZ_W) && (addr[1:0] != 2'b00));
  assign mis_trap   = acc && misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        misalign_q <= 1'b0;
    else if (mis_trap) misalign_q <= 1'b1;
  end

  assign misalign_err = misalign_q;
`else
  assign mis_trap     = 1'b0;
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mmio.sv
// Directed self-checking bench for lsu_mmio; follows LSU_MISALIGN_TRAP_EN like the RTL.
module tb_lsu_mmio;

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_NONE = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode_e;
  logic [2:0]  fun3_e;
  logic [31:0] addr, wd, dm_rdata;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_mask;
  logic        dm_we;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic [31:0] load_data;
  logic        load_valid, stall, misalign_err, map_err;

  int errors = 0;
  int checks = 0;

  lsu_mmio #(.UART_FIFO_DEPTH(4), .UART_PAGE(20'd1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_e(opcode_e), .fun3_e(fun3_e), .addr(addr), .wd(wd),
    .dm_rdata(dm_rdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_mask(dm_mask), .dm_we(dm_we),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .load_data(load_data), .load_valid(load_valid), .stall(stall),
    .misalign_err(misalign_err), .map_err(map_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    opcode_e = op; fun3_e = f3; addr = a; wd = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; uart_tx_ready = 1'b0; dm_rdata = 32'h0;
    drive(OP_NONE, 3'b000, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL rst_load_valid: got %b exp 0", load_valid); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rst_load_data: got %h exp 0", load_data); end
    checks++; if (map_err !== 1'b0) begin errors++; $display("FAIL rst_map_err: got %b exp 0", map_err); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign_err: got %b exp 0", misalign_err); end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b exp 0", uart_tx_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stall); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_dmem();
    drive(OP_ST, 3'b000, 32'h0000_0003, 32'h0000_00A5); #1;
    checks++; if (dm_mask !== 4'b1000) begin errors++; $display("FAIL sb_mask: got %b exp 1000", dm_mask); end
    checks++; if (dm_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata: got %h exp a5a5a5a5", dm_wdata); end
    checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b exp 1", dm_we); end
    checks++; if (dm_addr !== 32'h0) begin errors++; $display("FAIL sb_addr: got %h exp 0", dm_addr); end
    drive(OP_ST, 3'b001, 32'h0000_0012, 32'hFFFF_1234); #1;
    checks++; if (dm_mask !== 4'b1100) begin errors++; $display("FAIL sh_mask: got %b exp 1100", dm_mask); end
    checks++; if (dm_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata: got %h exp 12341234", dm_wdata); end
    checks++; if (dm_addr !== 32'h0000_0010) begin errors++; $display("FAIL sh_addr: got %h exp 10", dm_addr); end
    drive(OP_ST, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF); #1;
    checks++; if (dm_mask !== 4'b1111) begin errors++; $display("FAIL sw_mask: got %b exp 1111", dm_mask); end
    checks++; if (dm_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h exp deadbeef", dm_wdata); end
    drive(OP_ST, 3'b011, 32'h0000_0044, 32'hCAFE_F00D); #1;
    checks++; if (dm_mask !== 4'b1111) begin errors++; $display("FAIL illegal_f3_mask: got %b exp 1111", dm_mask); end
    checks++; if (dm_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL illegal_f3_wdata: got %h exp cafef00d", dm_wdata); end
    drive(OP_ST, 3'b010, 32'h0000_1000, 32'h0); #1;
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL uart_store_we: got %b exp 0", dm_we); end
    drive(OP_NONE, 3'b010, 32'h0000_0040, 32'h0); #1;
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %b exp 0", dm_we); end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] rd;
    logic [31:0] exp;
  } ld_vec_t;

  task automatic test_load_dmem();
    ld_vec_t v [10];
    v[0] = '{3'b000, 32'h2, 32'h0080_0000, 32'hFFFF_FF80};
    v[1] = '{3'b100, 32'h2, 32'h0080_0000, 32'h0000_0080};
    v[2] = '{3'b000, 32'h1, 32'h0000_7F00, 32'h0000_007F};
    v[3] = '{3'b000, 32'h0, 32'h0000_00FF, 32'hFFFF_FFFF};
    v[4] = '{3'b100, 32'h3, 32'hAB00_0000, 32'h0000_00AB};
    v[5] = '{3'b001, 32'h2, 32'h8001_0000, 32'hFFFF_8001};
    v[6] = '{3'b101, 32'h2, 32'h8001_0000, 32'h0000_8001};
    v[7] = '{3'b001, 32'h0, 32'h1234_7FFE, 32'h0000_7FFE};
    v[8] = '{3'b010, 32'h4, 32'h89AB_CDEF, 32'h89AB_CDEF};
    v[9] = '{3'b111, 32'h8, 32'h0102_0304, 32'h0102_0304};
    for (int i = 0; i < 10; i++) begin
      drive(OP_LD, v[i].f3, v[i].a, 32'h0); dm_rdata = 32'h0;
      tick();
      drive(OP_NONE, 3'b000, 32'h0, 32'h0); dm_rdata = v[i].rd; #1;
      checks++; if (load_valid !== 1'b1) begin errors++; $display("FAIL load_valid[%0d]: got %b exp 1", i, load_valid); end
      checks++; if (load_data !== v[i].exp) begin errors++; $display("FAIL load_data[%0d]: got %h exp %h", i, load_data, v[i].exp); end
    end
    tick();
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL load_valid_idle: got %b exp 0", load_valid); end
  endtask

  task automatic test_uart_fifo();
    logic [7:0] exp_q [4];
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(OP_ST, 3'b010, 32'h0000_1000, 32'(8'h11 * (i + 1))); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_fill[%0d]: got %b exp 0", i, stall); end
      tick();
    end
    drive(OP_ST, 3'b010, 32'h0000_1000, 32'h0000_0055); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_full: got %b exp 1", stall); end
    checks++; if (uart_tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_full: got %b exp 1", uart_tx_valid); end
    checks++; if (uart_tx_data !== 8'h11) begin errors++; $display("FAIL head_first: got %h exp 11", uart_tx_data); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b exp 1", stall); end
    uart_tx_ready = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_during_pop: got %b exp 1", stall); end
    tick();
    uart_tx_ready = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_release: got %b exp 0", stall); end
    checks++; if (uart_tx_data !== 8'h22) begin errors++; $display("FAIL head_after_pop: got %h exp 22", uart_tx_data); end
    tick();
    drive(OP_LD, 3'b010, 32'h0000_1004, 32'h0);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); #1;
    checks++; if (load_data !== 32'h0000_0402) begin errors++; $display("FAIL status_full: got %h exp 00000402", load_data); end
    checks++; if (map_err !== 1'b0) begin errors++; $display("FAIL status_map_err: got %b exp 0", map_err); end
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (uart_tx_data !== exp_q[i]) begin errors++; $display("FAIL drain[%0d]: got %h exp %h", i, uart_tx_data, exp_q[i]); end
      tick();
    end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL drained_valid: got %b exp 0", uart_tx_valid); end
    uart_tx_ready = 1'b0;
    drive(OP_LD, 3'b010, 32'h0000_1004, 32'h0);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); #1;
    checks++; if (load_data !== 32'h0000_0001) begin errors++; $display("FAIL status_empty: got %h exp 00000001", load_data); end
    for (int i = 0; i < 3; i++) begin
      drive(OP_ST, 3'b000, 32'h0000_1000, 32'(8'hA1 + i));
      tick();
    end
    drive(OP_LD, 3'b010, 32'h0000_1004, 32'h0);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); #1;
    checks++; if (load_data !== 32'h0000_0300) begin errors++; $display("FAIL status_three: got %h exp 00000300", load_data); end
    uart_tx_ready = 1'b1;
    drive(OP_ST, 3'b010, 32'h0000_1000, 32'h0000_00A4);
    tick();
    uart_tx_ready = 1'b0;
    drive(OP_LD, 3'b010, 32'h0000_1004, 32'h0);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); #1;
    checks++; if (load_data !== 32'h0000_0300) begin errors++; $display("FAIL push_pop_count: got %h exp 00000300", load_data); end
    checks++; if (uart_tx_data !== 8'hA2) begin errors++; $display("FAIL push_pop_head: got %h exp a2", uart_tx_data); end
  endtask

  task automatic test_reset_mid();
    drive(OP_LD, 3'b010, 32'h0000_0000, 32'h0); dm_rdata = 32'h1234_5678;
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0);
    rst_n = 1'b0; #1;
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL midrst_load_valid: got %b exp 0", load_valid); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL midrst_load_data: got %h exp 0", load_data); end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid: got %b exp 0", uart_tx_valid); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL postrst_tx_valid: got %b exp 0", uart_tx_valid); end
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL postrst_load_valid: got %b exp 0", load_valid); end
  endtask

  task automatic test_map_err();
    drive(OP_ST, 3'b010, 32'h0000_2000, 32'h0000_1234); #1;
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL unmapped_we: got %b exp 0", dm_we); end
    tick();
    checks++; if (map_err !== 1'b1) begin errors++; $display("FAIL unmapped_st_map_err: got %b exp 1", map_err); end
    drive(OP_NONE, 3'b000, 32'h0, 32'h0);
    tick();
    checks++; if (map_err !== 1'b0) begin errors++; $display("FAIL map_err_pulse_end: got %b exp 0", map_err); end
    drive(OP_ST, 3'b010, 32'h0000_1004, 32'h0000_0077);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); #1;
    checks++; if (map_err !== 1'b1) begin errors++; $display("FAIL status_store_map_err: got %b exp 1", map_err); end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL status_store_push: got %b exp 0", uart_tx_valid); end
    drive(OP_ST, 3'b000, 32'h0000_1008, 32'h0000_0077);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); #1;
    checks++; if (map_err !== 1'b1) begin errors++; $display("FAIL uart_hole_map_err: got %b exp 1", map_err); end
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL uart_hole_push: got %b exp 0", uart_tx_valid); end
    drive(OP_LD, 3'b010, 32'h0000_3000, 32'h0);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); dm_rdata = 32'hFFFF_FFFF; #1;
    checks++; if (load_valid !== 1'b1) begin errors++; $display("FAIL unmapped_ld_valid: got %b exp 1", load_valid); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL unmapped_ld_data: got %h exp 0", load_data); end
    checks++; if (map_err !== 1'b1) begin errors++; $display("FAIL unmapped_ld_map_err: got %b exp 1", map_err); end
    drive(OP_LD, 3'b010, 32'h0000_1000, 32'h0);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); #1;
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL txdata_ld_data: got %h exp 0", load_data); end
    checks++; if (map_err !== 1'b0) begin errors++; $display("FAIL txdata_ld_map_err: got %b exp 0", map_err); end
    tick();
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    drive(OP_ST, 3'b001, 32'h0000_0001, 32'h0000_BEEF); #1;
    checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL mis_sh_we: got %b exp 0", dm_we); end
    tick();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err_set: got %b exp 1", misalign_err); end
    drive(OP_NONE, 3'b000, 32'h0, 32'h0);
    tick();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_err_sticky: got %b exp 1", misalign_err); end
    drive(OP_LD, 3'b010, 32'h0000_0002, 32'h0);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); dm_rdata = 32'hFFFF_FFFF; #1;
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL mis_lw_data: got %h exp 0", load_data); end
    drive(OP_ST, 3'b010, 32'h0000_1001, 32'h0000_0066); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_tx_stall: got %b exp 0", stall); end
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); #1;
    checks++; if (uart_tx_valid !== 1'b0) begin errors++; $display("FAIL mis_tx_push: got %b exp 0", uart_tx_valid); end
`else
    drive(OP_ST, 3'b001, 32'h0000_0001, 32'h0000_BEEF); #1;
    checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL noalign_sh_we: got %b exp 1", dm_we); end
    checks++; if (dm_mask !== 4'b0011) begin errors++; $display("FAIL noalign_sh_mask: got %b exp 0011", dm_mask); end
    checks++; if (dm_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL noalign_sh_wdata: got %h exp beefbeef", dm_wdata); end
    drive(OP_LD, 3'b001, 32'h0000_0003, 32'h0);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); dm_rdata = 32'h8001_1234; #1;
    checks++; if (load_data !== 32'hFFFF_8001) begin errors++; $display("FAIL noalign_lh_data: got %h exp ffff8001", load_data); end
    drive(OP_LD, 3'b010, 32'h0000_0003, 32'h0);
    tick();
    drive(OP_NONE, 3'b000, 32'h0, 32'h0); dm_rdata = 32'h89AB_CDEF; #1;
    checks++; if (load_data !== 32'h89AB_CDEF) begin errors++; $display("FAIL noalign_lw_data: got %h exp 89abcdef", load_data); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL noalign_err: got %b exp 0", misalign_err); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_store_dmem();
    test_load_dmem();
    test_uart_fifo();
    test_reset_mid();
    test_map_err();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mmio.md
LSU_MMIO -- requirements
Module: lsu_mmio

Interface
REQ-001 Parameter UART_FIFO_DEPTH, default 4, UART transmit FIFO entries; power of two, minimum 2.
REQ-002 Parameter UART_PAGE, default 20'd1, value of addr[31:12] selecting UART registers; DMEM page is fixed at 20'd0.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 opcode_e  in  7  execute-stage opcode; 0000011 load, 0100011 store, anything else idle.
REQ-006 fun3_e  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 addr  in  32  effective address; wd  in  32  store data.
REQ-008 dm_rdata  in  32  DMEM read word, valid one cycle after dm_addr.
REQ-009 dm_addr  out  32  word-aligned DMEM address; dm_wdata  out  32; dm_mask  out  4 byte enables; dm_we  out  1.
REQ-010 uart_tx_data  out  8; uart_tx_valid  out  1; uart_tx_ready  in  1  transmitter handshake.
REQ-011 load_data  out  32; load_valid  out  1  load result strobe.
REQ-012 stall  out  1  hold execute stage; misalign_err  out  1  sticky; map_err  out  1  one-cycle pulse.

Function
REQ-013 Decode: addr[31:12]==0 DMEM; ==UART_PAGE UART (offset 0x000 TXDATA write-only, 0x004 STATUS read-only); else unmapped.
REQ-014 Store byte: dm_mask = 1<<addr[1:0], dm_wdata = wd[7:0] replicated x4.
REQ-015 Store half: dm_mask 0011 (addr[1]=0) or 1100 (addr[1]=1), dm_wdata = wd[15:0] replicated x2; store word: mask 1111, dm_wdata = wd.
REQ-016 dm_we combinational, asserted only for an aligned store to DMEM; dm_addr = {addr[31:2],2'b00}.
REQ-017 Loads: 1-cycle latency; cycle N registers addr[1:0], fun3_e, region; cycle N+1 load_valid=1 and load_data from dm_rdata lane.
REQ-018 Lane select by registered addr[1:0]; b/h sign-extend, bu/hu zero-extend, w passes through.
REQ-019 STATUS load returns {16'b0, count[7:0], 6'b0, full, empty}; TXDATA load or unmapped load returns 0 with load_valid=1.
REQ-020 Store to TXDATA pushes wd[7:0] into FIFO when not full.
REQ-021 Store to TXDATA while full: stall=1 combinationally, no push; stall depends on full only, not same-cycle pop.
REQ-022 uart_tx_valid = !empty, uart_tx_data = FIFO head; pop when uart_tx_valid && uart_tx_ready.
REQ-023 Simultaneous push and pop (not full): both occur, count unchanged; pointers wrap modulo depth.
REQ-024 Unmapped load/store, or store to STATUS: map_err pulses one cycle; no DMEM write, no FIFO push.
REQ-025 Illegal fun3_e (011,110,111) on load/store: treated as word access.

Reset
REQ-026 rst_n low: FIFO emptied, pointers/count 0, load_valid 0, load_data 0, misalign_err 0, map_err 0, uart_tx_valid 0.
REQ-027 Reset mid-load drops the pending result; reset while FIFO holds bytes discards them.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN defined: half on addr[0]=1 or word on addr[1:0]!=0 suppresses DMEM write/FIFO push, load returns 0, sets misalign_err (sticky until reset).
REQ-029 Macro undefined: misalignment ignored; address aligned down to access size; misalign_err tied 0.

Verification
REQ-030 sb addr=0x0000_0003 wd=0x0000_00A5 -> dm_mask 1000, dm_wdata 0xA5A5A5A5, dm_we 1.
REQ-031 lb addr=0x0000_0002, dm_rdata=0x0080_0000 next cycle -> load_valid 1, load_data 0xFFFF_FF80; lbu -> 0x0000_0080.
REQ-032 Depth 4, uart_tx_ready=0, five sw to 0x0000_1000 -> 4 pushed, fifth held with stall=1; ready=1 one cycle -> stall drops next cycle, fifth pushed.
REQ-033 lw 0x0000_1004 with 3 bytes queued -> load_data 0x0000_0300.
REQ-034 sw 0x0000_2000 -> map_err pulse, dm_we 0; with LSU_MISALIGN_TRAP_EN, sh 0x0000_0001 -> misalign_err 1, dm_we 0.
